// File: rtl/ccc_ctrl_pkg.sv
// ccc_ctrl_pkg: shared state encoding, counter widths and default timing for the CCC lock/reset sequencer
package ccc_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_ARST   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } ccc_state_e;
    localparam int RETRY_W = 2;
    localparam int LOSS_W = 8;
    localparam int DEF_ARST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES = 3;
    localparam int DEF_SYNC_STAGES = 2;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/ccc_lock_sync.sv
// ccc_lock_sync: multi-flop synchronizer bringing the asynchronous PLL LOCK into the reference clock domain
module ccc_lock_sync
    import ccc_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic lock,
    output logic lk
);
    logic [SYNC_STAGES-1:0] s;
    always_ff @(posedge clk)
        s <= rst ? '0 : {s[SYNC_STAGES-2:0], lock};
    assign lk = s[SYNC_STAGES-1];
endmodule

// File: rtl/ccc_lock_reset_ctrl.sv
// ccc_lock_reset_ctrl: holds the PLL in reset, qualifies LOCK and releases the GL0 fabric reset, with retry/fault handling
module ccc_lock_reset_ctrl
    import ccc_ctrl_pkg::*;
#(
    parameter int ARST_CYCLES   = DEF_ARST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PLL_LOCK,
    input  logic               REQ_RELOCK,
    output logic               PLL_ARST_N,
    output logic               PLL_POWERDOWN_N,
    output logic               FABRIC_RESET_N,
    output logic               LOCKED,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_CNT,
    output logic [LOSS_W-1:0]  LOSS_CNT,
    output logic [2:0]         STATE
);
    localparam int CMAX = max3(ARST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
    ccc_state_e state, nxt;
    logic [CW-1:0] cnt;
    logic [RETRY_W-1:0] retry_inc;
    logic lk, timeout, relock;
    ccc_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (CLK),
        .rst (RESET),
        .lock(PLL_LOCK),
        .lk  (lk)
    );
    assign retry_inc = RETRY_CNT + RETRY_W'(1);
    assign relock = REQ_RELOCK && state != ST_ARST;
    assign STATE = state;
    always_comb begin
        nxt = state;
        timeout = 1'b0;
        case (state)
            ST_ARST:   nxt = (cnt == CW'(ARST_CYCLES - 1)) ? ST_WAIT : ST_ARST;
            ST_WAIT: begin
                timeout = !relock && !lk && cnt == CW'(LOCK_TIMEOUT - 1);
                nxt = relock ? ST_ARST : lk ? ST_STABLE :
                      !timeout ? ST_WAIT :
                      (retry_inc == RETRY_W'(MAX_RETRIES)) ? ST_FAULT : ST_ARST;
            end
            ST_STABLE: nxt = relock ? ST_ARST : !lk ? ST_WAIT :
                             (cnt == CW'(STABLE_CYCLES - 1)) ? ST_RUN : ST_STABLE;
            ST_RUN:    nxt = (relock || !lk) ? ST_ARST : ST_RUN;
            ST_FAULT:  nxt = relock ? ST_ARST : ST_FAULT;
            default:   nxt = ST_ARST;
        endcase
    end
    // outputs are registered from the next state so they move on the same edge as STATE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= ST_ARST;
            cnt             <= '0;
            PLL_ARST_N      <= 1'b0;
            PLL_POWERDOWN_N <= 1'b1;
            FABRIC_RESET_N  <= 1'b0;
            LOCKED          <= 1'b0;
            FAULT           <= 1'b0;
            RETRY_CNT       <= '0;
            LOSS_CNT        <= '0;
        end else begin
            state           <= nxt;
            cnt             <= (nxt != state) ? '0 : cnt + CW'(1);
            PLL_ARST_N      <= !(nxt == ST_ARST || nxt == ST_FAULT);
            PLL_POWERDOWN_N <= nxt != ST_FAULT;
            FABRIC_RESET_N  <= nxt == ST_RUN;
            LOCKED          <= nxt == ST_RUN;
            FAULT           <= nxt == ST_FAULT;
            RETRY_CNT       <= (relock || (state == ST_STABLE && nxt == ST_RUN)) ? '0 :
                               timeout ? retry_inc : RETRY_CNT;
            LOSS_CNT        <= (state == ST_RUN && !lk && LOSS_CNT != '1) ? LOSS_CNT + LOSS_W'(1) : LOSS_CNT;
        end
    end
endmodule

// File: doc/ccc_lock_reset_ctrl.md
# ccc_lock_reset_ctrl

Sequencer for the fabric CCC/PLL. Holds the PLL in reset after power-up, waits for LOCK and then qualifies it for stability. Only after that does it release the fabric reset for logic clocked by GL0. On loss of lock or a software request it re-runs the sequence, and after repeated lock timeouts it parks in a sticky fault state. It runs on the free-running reference clock that feeds the CCC CLK0 input, never on GL0.

## Interface
Parameters:
- ARST_CYCLES, 16: PLL_ARST_N low pulse length, cycles.
- LOCK_TIMEOUT, 50000: max cycles to wait for lock per attempt.
- STABLE_CYCLES, 1024: consecutive synced-lock cycles required before release.
- MAX_RETRIES, 3: consecutive lock timeouts before FAULT.
- SYNC_STAGES, 2: LOCK synchronizer depth, ≥2.

Ports:
- CLK  in  1  reference clock, same source as CCC CLK0.
- RESET  in  1  synchronous, active-high.
- PLL_LOCK  in  1  CCC LOCK, asynchronous to CLK.
- REQ_RELOCK  in  1  single-cycle software request to restart the sequence.
- PLL_ARST_N  out  1  to CCC PLL_ARST_N.
- PLL_POWERDOWN_N  out  1  to CCC PLL_POWERDOWN_N.
- FABRIC_RESET_N  out  1  reset release for the GL0 domain; consumer re-synchronizes it.
- LOCKED  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- RETRY_CNT  out  2  timeouts in the current attempt series.
- LOSS_CNT  out  8  lock losses seen in RUN, saturating at 255.
- STATE  out  3  current state encoding.

## Operation
- LOCK passes through a SYNC_STAGES flop chain. Every decision below uses the synced value `lk`.
- States and encodings: ARST=0, WAIT=1, STABLE=2, RUN=3, FAULT=4. One shared counter `cnt` is cleared on every state entry.
- ARST
  - PLL_ARST_N=0.
  - After ARST_CYCLES cycles, go to WAIT.
- WAIT
  - If `lk`=1, go to STABLE. This has priority over timeout in the same cycle.
  - Else, when `cnt` reaches LOCK_TIMEOUT-1, increment RETRY_CNT. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to ARST.
- STABLE
  - If `lk`=0, go to WAIT. The timeout count restarts.
  - After STABLE_CYCLES consecutive `lk`=1 cycles, go to RUN and clear RETRY_CNT.
- RUN
  - FABRIC_RESET_N=1 and LOCKED=1.
  - If `lk`=0, go to ARST and increment LOSS_CNT (saturating).
- FAULT
  - PLL_ARST_N=0 and PLL_POWERDOWN_N=0.
  - Exit only on RESET or REQ_RELOCK.
- REQ_RELOCK
  - In WAIT, STABLE, RUN or FAULT: go to ARST and clear RETRY_CNT.
  - Ignored in ARST.
  - In RUN with a simultaneous lock drop: go to ARST once and still increment LOSS_CNT.
- FABRIC_RESET_N is 0 in every state except RUN.
- PLL_POWERDOWN_N is 1 except in FAULT.
- Counter width: $clog2 of max(ARST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). RETRY_CNT never exceeds MAX_RETRIES.

## Timing
- Reset values:
  - STATE=ARST, cnt=0.
  - PLL_ARST_N=0, PLL_POWERDOWN_N=1, FABRIC_RESET_N=0.
  - LOCKED=0, FAULT=0, RETRY_CNT=0, LOSS_CNT=0.
  - Synchronizer flops cleared.
- Outputs are registered and change in the cycle after the state transition that causes them.
- PLL_ARST_N low pulse is exactly ARST_CYCLES cycles when uninterrupted.
- A PLL_LOCK edge reaches `lk` after SYNC_STAGES cycles.
- Lock drop in RUN to FABRIC_RESET_N=0: SYNC_STAGES+1 cycles.
- Lock stable to FABRIC_RESET_N=1: SYNC_STAGES+STABLE_CYCLES+1 cycles.
- RESET asserted mid-sequence: takes effect at the next edge, with all outputs at reset values and LOSS_CNT cleared.

## Structure
- Package ccc_ctrl_pkg holds:
  - the state enum and its 3-bit encodings;
  - the RETRY_CNT and LOSS_CNT widths;
  - the default parameter constants.
- Sub-module ccc_lock_sync: parameterized SYNC_STAGES flop chain with synchronous clear on RESET.
- All other logic is a single FSM plus counters in ccc_lock_reset_ctrl.

## Test plan
Bench parameters: ARST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Nominal bring-up: release RESET, raise PLL_LOCK at cycle 10 and hold it.
  - PLL_ARST_N low exactly 4 cycles.
  - FABRIC_RESET_N rises 11 cycles after the lock edge; LOCKED=1 and STATE=3.
- Glitchy lock: PLL_LOCK high 5 cycles, low 1, then high.
  - Returns to WAIT, then STABLE again.
  - Release occurs only after 8 uninterrupted cycles; no timeout is counted.
- Timeouts to fault: PLL_LOCK held low.
  - After two ARST/WAIT rounds, RETRY_CNT=2, FAULT=1, PLL_POWERDOWN_N=0.
  - State remains FAULT for 100 cycles.
- Recovery from fault: pulse REQ_RELOCK while in FAULT with PLL_LOCK high.
  - Next state is ARST with RETRY_CNT=0.
  - Reaches RUN; FAULT=0.
- Loss in RUN: drop PLL_LOCK while in RUN, 300 times.
  - FABRIC_RESET_N falls 3 cycles after each drop.
  - LOSS_CNT saturates at 255; each loss restarts the ARST pulse.
- Corner cases:
  - Timeout cycle coincides with `lk` rising: goes to STABLE and RETRY_CNT is unchanged.
  - RESET in STABLE: all outputs return to reset values at the next edge.
